pulse_stretcher: RTL and testbench
==================================

Name: pulse_stretcher

Overview:
- Inverse of the team's Mealy edge detector: converts single-cycle ticks into a level pulse of programmable width.
- Used to drive LEDs, strobes and external enables from internal one-cycle events.
- Configurable retrigger behaviour, a guaranteed minimum low gap between pulses, and accounting of ticks that were dropped.

Parameters:
- W, 8, width of the len input and of the internal down-counter.
- GAP, 2, minimum level-low cycles forced after each pulse (0 allowed).
- RETRIG, 0, 1 = a tick while level is high restarts the full width; 0 = such a tick is dropped.
- CW, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  single-cycle event request, synchronous to clk.
- len  input  W  pulse width in cycles; sampled only when a pulse is started or restarted.
- drop_clr  input  1  synchronous clear of drop_cnt.
- level  output  1  stretched pulse, registered.
- busy  output  1  high whenever the FSM is not IDLE (decoded from the state register only).
- drop  output  1  one-cycle registered flag: a tick was discarded.
- drop_cnt  output  CW  saturating count of discarded ticks.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, counter=0, level=0, busy=0, drop=0, drop_cnt=0.
  - Reset asserted mid-pulse or mid-gap aborts immediately; level falls with reset.
- States: IDLE, HIGH, HOLD. Encoding is 2-bit binary; the unused code returns to IDLE.
- IDLE:
  - tick=1 in cycle n: go to HIGH, load counter with eff_len-1, where eff_len = (len==0) ? 1 : len.
  - level is high in cycles n+1 .. n+eff_len. Latency tick to level = 1 cycle.
- HIGH:
  - counter decrements each cycle.
  - When counter==0 and no accepted tick: go to HOLD with counter=GAP-1 if GAP>0, else go to IDLE.
- HOLD:
  - level=0; counter decrements.
  - counter==0: go to IDLE. The first tick accepted again is in cycle n+eff_len+GAP+1.
- Tick in HIGH:
  - RETRIG=1: reload counter with the new eff_len-1. level stays high eff_len cycles after the latest tick, with no low glitch.
  - RETRIG=0: tick ignored; drop=1 next cycle; drop_cnt increments.
- Tick in HOLD: always dropped (drop, drop_cnt), regardless of RETRIG.
- Simultaneous events:
  - Tick on the last HIGH cycle with RETRIG=1: retrigger wins and the state stays HIGH.
  - Tick on the last HOLD cycle: dropped.
- drop_cnt:
  - Saturates at 2^CW-1; never wraps.
  - drop_clr has priority over a same-cycle increment: result is 0, and drop still pulses.
- level and drop are registered outputs with no combinational path from inputs.
- A len change while busy has no effect until the next start or restart.

Decomposition:
- Shared constants header/package pulse_pkg:
  - State codes ST_IDLE=2'd0, ST_HIGH=2'd1, ST_HOLD=2'd2.
  - Shared with any future tick/level utilities.
- Optional sub-module sat_counter (parameter CW; inputs inc, clr; output cnt) for drop_cnt; reusable elsewhere.
- The FSM and the down-counter stay in the top module.

Test Plan:
- Basic pulse. W=8, GAP=2, RETRIG=0, len=5, one tick at cycle 10 -> level=1 in cycles 11-15, 0 from cycle 16; busy 1 in cycles 11-17; drop stays 0.
- Zero length. len=0, tick at cycle 10 -> level high in cycle 11 only; behaves identically to len=1.
- Drop without retrigger. RETRIG=0, len=4, ticks at cycles 10, 12 and 15 (15 falls in HOLD) -> level high 11-14; drop pulses at cycles 13 and 16; drop_cnt=2; a tick at cycle 17 is accepted (level high from cycle 18).
- Retrigger. RETRIG=1, len=4, ticks at 10 and 13 -> level continuously high 11-17; drop_cnt stays 0. Same setup with the second tick at 14 (last HIGH cycle) -> level high 11-18, no low glitch.
- Saturation and clear. CW=2, eight dropped ticks -> drop_cnt holds at 3. drop_clr coincident with a drop -> drop_cnt=0 and drop=1.
- Async reset. Reset asserted mid-pulse (cycle 13 of a len=8 pulse) -> level, busy and drop go 0 immediately without a clock edge. After release, a tick is accepted from IDLE with 1-cycle latency.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared tick/level constants: FSM state codes used by the pulse stretcher
// and any future tick/level utilities.
package pulse_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HIGH = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

endpackage

// File: rtl/pulse_stretcher_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
// Ports: clk, reset (async, active-high), inc, clr, cnt[CW-1:0].
module sat_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] MAX = '1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches one-cycle ticks into a registered level pulse of len cycles,
// followed by a forced low gap of GAP cycles; counts discarded ticks.
// Ports: clk, reset (async, active-high), tick, len[W-1:0], drop_clr,
//        level, busy, drop, drop_cnt[CW-1:0].
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int W      = 8,
  parameter int GAP    = 2,
  parameter int RETRIG = 0,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic [W-1:0]  len,
  input  logic          drop_clr,
  output logic          level,
  output logic          busy,
  output logic          drop,
  output logic [CW-1:0] drop_cnt
);

  localparam bit RT = (RETRIG != 0);
  localparam logic [W-1:0] GAP_M1 =
    (GAP > 0) ? W'(GAP - 1) : '0;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_nxt;
  logic [W-1:0] w_eff_m1;
  logic         r_level;
  logic         r_drop;
  logic         w_drop;

  // len==0 behaves as len==1
  assign w_eff_m1 = (len == '0) ? '0 : len - 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (tick) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = w_eff_m1;
        end
      end
      ST_HIGH: begin
        if (tick && RT) begin
          // restart wins even on the last high cycle
          w_cnt_nxt = w_eff_m1;
        end else begin
          w_drop = tick;
          if (r_cnt == '0) begin
            if (GAP > 0) begin
              w_state_nxt = ST_HOLD;
              w_cnt_nxt   = GAP_M1;
            end else begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = '0;
            end
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
      end
      ST_HOLD: begin
        w_drop = tick;
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= (w_state_nxt == ST_HIGH);
      r_drop  <= w_drop;
    end
  end

  sat_counter #(
    .CW (CW)
  ) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_drop),
    .clr   (drop_clr),
    .cnt   (drop_cnt)
  );

  assign level = r_level;
  assign drop  = r_drop;
  assign busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: three parameter sets
// driven in parallel, directed tables/sequences plus random stimulus.
module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       drop_clr;
  logic [7:0] len;
  logic [2:0] lvl;
  logic [2:0] bsy;
  logic [2:0] drp;
  logic [7:0] dc0;
  logic [7:0] dc1;
  logic [1:0] dc2;

  always #5 clk = ~clk;

  pulse_stretcher #(.W(8), .GAP(2), .RETRIG(0), .CW(8)) u0 (
    .clk(clk), .reset(reset), .tick(tick), .len(len),
    .drop_clr(drop_clr), .level(lvl[0]), .busy(bsy[0]),
    .drop(drp[0]), .drop_cnt(dc0)
  );

  pulse_stretcher #(.W(8), .GAP(2), .RETRIG(1), .CW(8)) u1 (
    .clk(clk), .reset(reset), .tick(tick), .len(len),
    .drop_clr(drop_clr), .level(lvl[1]), .busy(bsy[1]),
    .drop(drp[1]), .drop_cnt(dc1)
  );

  pulse_stretcher #(.W(8), .GAP(0), .RETRIG(0), .CW(2)) u2 (
    .clk(clk), .reset(reset), .tick(tick), .len(len),
    .drop_clr(drop_clr), .level(lvl[2]), .busy(bsy[2]),
    .drop(drp[2]), .drop_cnt(dc2)
  );

  // Reference model: absolute cycle numbers of the last high cycle
  // and the last busy cycle, plus the drop bookkeeping.
  int gap_p [3] = '{2, 2, 0};
  int rt_p  [3] = '{0, 1, 0};
  int max_p [3] = '{255, 255, 3};
  int hi    [3];
  int ho    [3];
  int mcnt  [3];
  int mdrp  [3];
  int cyc;
  int checks;
  int errors;

  typedef struct {
    bit t;
    int l;
    bit lv;
    bit bs;
    bit dr;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t v(bit t, int l, bit lv, bit bs, bit dr);
    vec_t r;
    r.t = t; r.l = l; r.lv = lv; r.bs = bs; r.dr = dr;
    return r;
  endfunction

  function automatic int dcnt(int d);
    if (d == 0) return int'(dc0);
    if (d == 1) return int'(dc1);
    return int'(dc2);
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      hi[d] = -1; ho[d] = -1; mcnt[d] = 0; mdrp[d] = 0;
    end
  endtask

  // Check current-cycle outputs, apply inputs, advance one cycle.
  task automatic step(bit t, int l, bit c);
    int eff;
    bit dropped;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("level%0d", d), int'(lvl[d]), (cyc <= hi[d]) ? 1 : 0);
      chk($sformatf("busy%0d", d), int'(bsy[d]), (cyc <= ho[d]) ? 1 : 0);
      chk($sformatf("drop%0d", d), int'(drp[d]), mdrp[d]);
      chk($sformatf("drop_cnt%0d", d), dcnt(d), mcnt[d]);
    end
    tick = t;
    len = 8'(l);
    drop_clr = c;
    eff = (l == 0) ? 1 : l;
    for (int d = 0; d < 3; d++) begin
      dropped = 1'b0;
      if (t) begin
        if (cyc > ho[d] || (cyc <= hi[d] && rt_p[d] == 1)) begin
          hi[d] = cyc + eff;
          ho[d] = hi[d] + gap_p[d];
        end else begin
          dropped = 1'b1;
        end
      end
      mdrp[d] = dropped ? 1 : 0;
      if (c) mcnt[d] = 0;
      else if (dropped && mcnt[d] < max_p[d]) mcnt[d]++;
    end
    @(posedge clk);
    #1;
    cyc++;
    tick = 1'b0;
    drop_clr = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0;
    reset = 1'b1; tick = 1'b0; drop_clr = 1'b0; len = 8'd0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_level", int'(lvl[d]), 0);
      chk("rst_busy", int'(bsy[d]), 0);
      chk("rst_drop", int'(drp[d]), 0);
      chk("rst_cnt", dcnt(d), 0);
    end
    reset = 1'b0;

    // Basic len=5, zero length, drop without retrigger (u0 expectations)
    tbl[0]  = v(1, 5, 0, 0, 0);
    tbl[1]  = v(0, 5, 1, 1, 0);
    tbl[2]  = v(0, 5, 1, 1, 0);
    tbl[3]  = v(0, 9, 1, 1, 0);
    tbl[4]  = v(0, 5, 1, 1, 0);
    tbl[5]  = v(0, 5, 1, 1, 0);
    tbl[6]  = v(0, 5, 0, 1, 0);
    tbl[7]  = v(0, 5, 0, 1, 0);
    tbl[8]  = v(0, 5, 0, 0, 0);
    tbl[9]  = v(1, 0, 0, 0, 0);
    tbl[10] = v(0, 0, 1, 1, 0);
    tbl[11] = v(0, 0, 0, 1, 0);
    tbl[12] = v(0, 0, 0, 1, 0);
    tbl[13] = v(0, 0, 0, 0, 0);
    tbl[14] = v(1, 4, 0, 0, 0);
    tbl[15] = v(0, 4, 1, 1, 0);
    tbl[16] = v(1, 4, 1, 1, 0);
    tbl[17] = v(0, 4, 1, 1, 1);
    tbl[18] = v(0, 4, 1, 1, 0);
    tbl[19] = v(1, 4, 0, 1, 0);
    tbl[20] = v(0, 4, 0, 1, 1);
    tbl[21] = v(1, 4, 0, 0, 0);
    tbl[22] = v(0, 4, 1, 1, 0);
    tbl[23] = v(0, 4, 1, 1, 0);
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("tbl%0d_level", i), int'(lvl[0]), int'(tbl[i].lv));
      chk($sformatf("tbl%0d_busy", i), int'(bsy[0]), int'(tbl[i].bs));
      chk($sformatf("tbl%0d_drop", i), int'(drp[0]), int'(tbl[i].dr));
      step(tbl[i].t, tbl[i].l, 1'b0);
    end
    chk("tbl_drop_cnt", int'(dc0), 2);
    idle(12);

    // Retrigger mid-pulse (u1)
    step(1'b0, 0, 1'b1);
    step(1'b1, 4, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      chk("retrig_a_level", int'(lvl[1]), 1);
      step(k == 3, 4, 1'b0);
    end
    chk("retrig_a_end", int'(lvl[1]), 0);
    chk("retrig_a_cnt", int'(dc1), 0);
    idle(10);

    // Retrigger on the last high cycle (u1)
    step(1'b1, 4, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      chk("retrig_b_level", int'(lvl[1]), 1);
      step(k == 4, 4, 1'b0);
    end
    chk("retrig_b_end", int'(lvl[1]), 0);
    idle(10);

    // Saturation (u2, CW=2) and clear coincident with a drop
    step(1'b0, 0, 1'b1);
    step(1'b1, 20, 1'b0);
    for (int k = 1; k <= 8; k++) step(1'b1, 20, 1'b0);
    chk("sat_cnt2", int'(dc2), 3);
    chk("sat_cnt0", int'(dc0), 8);
    chk("sat_drop2", int'(drp[2]), 1);
    step(1'b1, 20, 1'b1);
    chk("clr_drop2", int'(drp[2]), 1);
    chk("clr_cnt2", int'(dc2), 0);
    chk("clr_cnt0", int'(dc0), 0);
    idle(40);

    // Async reset mid-pulse with a drop pending
    step(1'b1, 8, 1'b0);
    step(1'b0, 8, 1'b0);
    step(1'b1, 8, 1'b0);
    chk("pre_rst_level", int'(lvl[0]), 1);
    chk("pre_rst_drop", int'(drp[0]), 1);
    #2;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("arst_level", int'(lvl[d]), 0);
      chk("arst_busy", int'(bsy[d]), 0);
      chk("arst_drop", int'(drp[d]), 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc++;
    model_reset();
    step(1'b1, 3, 1'b0);
    chk("post_rst_latency", int'(lvl[0]), 1);
    idle(6);

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      bit t;
      bit c;
      int l;
      t = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 31) == 0);
      l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40))
                                      : int'($urandom_range(0, 12));
      step(t, l, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
